id_ex: RTL and testbench

Pipeline register between decode/operand-fetch and the combinational `ex` stage. Captures one decoded instruction per cycle (instruction word, destination register, two operands) and presents it to `ex` with valid/ready flow control. A one-entry skid buffer keeps `ready_o` a pure function of registered state, so upstream never sees a combinational path from downstream `ready_i`. When no instruction is valid, the block drives a canonical NOP to `ex`, so `ex` needs no valid gating.

---
 rtl/id_ex.sv | 101 ++++++++++
 tb/tb_id_ex.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/id_ex.sv
// ID/EX pipeline register: one decoded instruction per cycle to the ex stage, with a
// one-entry skid buffer so ready_o never depends combinationally on ready_i.
module id_ex #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] inst_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] inst_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o
);

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_t;

  localparam entry_t NOP_ENTRY = '{inst: NOP_INST, waddr: 5'd0, op1: 32'd0, op2: 32'd0};

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  entry_t out_entry;
  logic   acc;
  logic   drn;

  assign in_entry = '{inst: inst_i, waddr: reg_waddr_i, op1: op1_i, op2: op2_i};

  // Both handshakes are derived from the state register only, never from each other.
  assign ready_o = (state != FULL);
  assign valid_o = (state != EMPTY);
  assign acc     = valid_i & ready_o;
  assign drn     = valid_o & ready_i;

  // Forcing NOP while invalid lets ex consume the outputs without looking at valid_o.
  assign out_entry   = valid_o ? main_q : NOP_ENTRY;
  assign inst_o      = out_entry.inst;
  assign reg_waddr_o = out_entry.waddr;
  assign op1_o       = out_entry.op1;
  assign op2_o       = out_entry.op2;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the skid-to-main move order dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      // NOTE: the data entries are reset too, so nothing stale survives reset even
      // if the output muxing changes later.
      main_q <= NOP_ENTRY;
      skid_q <= NOP_ENTRY;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_entry;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (acc && drn) begin
            main_q <= in_entry;
          end else if (acc) begin
            skid_q <= in_entry;
            state  <= FULL;
          end else if (drn) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drn) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex.sv
// Directed self-checking bench for id_ex: reset, streaming, stall/skid, flush, bubble,
// and reset while full, each compared against hand-written expected entries.
module tb_id_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] inst_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  waddr;
    logic [31:0] op1;
    logic [31:0] op2;
  } ins_t;

  ins_t s0 = '{32'h00708293, 5'd5, 32'd10, 32'd7};
  ins_t s1 = '{32'h00310313, 5'd6, 32'd20, 32'd3};
  ins_t s2 = '{32'h00c18393, 5'd7, 32'd30, 32'd12};
  ins_t s3 = '{32'h00020413, 5'd8, 32'd40, 32'd0};
  ins_t ia = '{32'h00100093, 5'd1, 32'h11111111, 32'd1};
  ins_t ib = '{32'h00200113, 5'd2, 32'h22222222, 32'd2};
  ins_t ic = '{32'h00300193, 5'd3, 32'h33333333, 32'd3};
  ins_t id = '{32'h00400213, 5'd4, 32'h44444444, 32'd4};

  always #5 clk = ~clk;

  id_ex dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .inst_i     (inst_i),
    .reg_waddr_i(reg_waddr_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .inst_o     (inst_o),
    .reg_waddr_o(reg_waddr_o),
    .op1_o      (op1_o),
    .op2_o      (op2_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input ins_t e);
    valid_i     = 1'b1;
    inst_i      = e.inst;
    reg_waddr_i = e.waddr;
    op1_i       = e.op1;
    op2_i       = e.op2;
  endtask

  task automatic idle();
    valid_i     = 1'b0;
    inst_i      = 32'hdeadbeef;
    reg_waddr_i = 5'd31;
    op1_i       = 32'hffffffff;
    op2_i       = 32'hffffffff;
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input ins_t e, input logic exp_ready);
    check({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, ".ready"}, {31'd0, ready_o}, {31'd0, exp_ready});
    check({tag, ".inst"},  inst_o, e.inst);
    check({tag, ".waddr"}, {27'd0, reg_waddr_o}, {27'd0, e.waddr});
    check({tag, ".op1"},   op1_o, e.op1);
    check({tag, ".op2"},   op2_o, e.op2);
  endtask

  task automatic expect_nop(input string tag);
    check({tag, ".valid"}, {31'd0, valid_o}, 32'd0);
    check({tag, ".ready"}, {31'd0, ready_o}, 32'd1);
    check({tag, ".inst"},  inst_o, 32'h00000013);
    check({tag, ".waddr"}, {27'd0, reg_waddr_o}, 32'd0);
    check({tag, ".op1"},   op1_o, 32'd0);
    check({tag, ".op2"},   op2_o, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(s0);

    // Reset with valid_i high: the input must not be captured.
    tick();
    rst = 1'b0;
    idle();
    expect_nop("reset");
    tick();
    expect_nop("reset_after");

    // Streaming: four back-to-back instructions, one per cycle.
    ready_i = 1'b1;
    drive(s0); tick(); expect_out("stream0", s0, 1'b1);
    drive(s1); tick(); expect_out("stream1", s1, 1'b1);
    drive(s2); tick(); expect_out("stream2", s2, 1'b1);
    drive(s3); tick(); expect_out("stream3", s3, 1'b1);
    idle();    tick(); expect_nop("stream_end");

    // Stall / skid: A held, B goes to skid, C waits upstream.
    ready_i = 1'b0;
    drive(ia); tick(); expect_out("stall_a", ia, 1'b1);
    drive(ib); tick(); expect_out("stall_full", ia, 1'b0);
    drive(ic); tick(); expect_out("stall_hold", ia, 1'b0);
    ready_i = 1'b1;
    tick(); expect_out("drain_b", ib, 1'b1);
    tick(); expect_out("drain_c", ic, 1'b1);
    idle();
    tick(); expect_nop("drain_end");

    // Flush while FULL with a new valid input D in the same cycle.
    ready_i = 1'b0;
    drive(ia); tick(); expect_out("fl_a", ia, 1'b1);
    drive(ib); tick(); expect_out("fl_full", ia, 1'b0);
    flush_i = 1'b1;
    drive(id); tick(); expect_nop("flush");
    flush_i = 1'b0;
    idle();
    ready_i = 1'b1;
    tick(); expect_nop("flush_after");

    // Bubble: A, two idle cycles, then B.
    drive(ia); tick(); expect_out("bub_a", ia, 1'b1);
    idle();    tick(); expect_nop("bub_gap0");
    tick();            expect_nop("bub_gap1");
    drive(ib); tick(); expect_out("bub_b", ib, 1'b1);
    idle();    tick(); expect_nop("bub_end");

    // Reset while FULL: held entries must never reach the output.
    ready_i = 1'b0;
    drive(ia); tick(); expect_out("rs_a", ia, 1'b1);
    drive(ib); tick(); expect_out("rs_full", ia, 1'b0);
    rst = 1'b1;
    drive(ic); tick(); expect_nop("rst_full");
    rst = 1'b0;
    idle();
    ready_i = 1'b1;
    tick(); expect_nop("rst_after");
    drive(s1); tick(); expect_out("rst_resume", s1, 1'b1);
    idle();    tick(); expect_nop("rst_resume_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
